// File: rtl/board_pkg.sv
// Shared constants, piece codes and reader state encoding for the read side of the board bus.
// Consumed by board_reader and board_next_square.
package board_pkg;

  localparam int SQUARES  = 64;
  localparam int PIECE_W  = 4;
  localparam int SQ_W     = $clog2(SQUARES);
  localparam int BOARD_W  = SQUARES * PIECE_W;
  localparam int MOVE_W   = 14;
  localparam int TURN_BIT = 13;

  localparam logic [PIECE_W-1:0] PIECE_EMPTY = 4'h0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } reader_state_e;

endpackage

// File: rtl/board_next_square.sv
// Combinational priority search for the nearest non-empty square relative to base_i.
// Only built with BOARD_READER_SKIP_EMPTY_EN; DESCEND=1 searches downward instead.
`ifdef BOARD_READER_SKIP_EMPTY_EN
module board_next_square
  import board_pkg::*;
#(
  parameter bit DESCEND = 1'b0
) (
  input  logic [BOARD_W-1:0] board_i,
  input  logic [SQ_W-1:0]    base_i,
  input  logic               incl_i,
  output logic [SQ_W-1:0]    idx_o,
  output logic               none_o
);

  logic [SQ_W-1:0]    sq;
  logic [PIECE_W-1:0] pc;
  logic               in_range;

  // NOTE: every output and temporary gets a default before the loop, so no path infers a latch.
  always_comb begin
    idx_o    = '0;
    none_o   = 1'b1;
    sq       = '0;
    pc       = '0;
    in_range = 1'b0;
    // Scan away from the winning end so the closest hit is written last.
    for (int i = 0; i < SQUARES; i++) begin
      sq = DESCEND ? SQ_W'(i) : SQ_W'(SQUARES - 1 - i);
      pc = board_i[sq*PIECE_W +: PIECE_W];
      in_range = DESCEND ? ((sq < base_i) || (incl_i && (sq == base_i)))
                         : ((sq > base_i) || (incl_i && (sq == base_i)));
      if (in_range && (pc != PIECE_EMPTY)) begin
        idx_o  = sq;
        none_o = 1'b0;
      end
    end
  end

endmodule
`endif

// File: rtl/board_reader.sv
// Snapshots the packed board on start and streams it one square per valid/ready beat.
// Define BOARD_READER_SKIP_EMPTY_EN to stream only non-empty squares.
module board_reader
  import board_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [BOARD_W-1:0] board,
  input  logic [MOVE_W-1:0]  moveData,
  input  logic               start,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [SQ_W-1:0]    out_square,
  output logic [PIECE_W-1:0] out_piece,
  output logic               out_turn,
  output logic               out_last,
  output logic               frame_done
);

  reader_state_e      state_q, state_d;
  logic [BOARD_W-1:0] snap_q, snap_d;
  logic [SQ_W-1:0]    idx_q, idx_d;
  logic               turn_q, turn_d;

  logic [SQ_W-1:0]    first_sq, next_sq;
  logic               first_none, is_last;
  logic               unused_move;

  assign unused_move = ^{moveData[MOVE_W-1:TURN_BIT+1], moveData[TURN_BIT-1:0]};

`ifdef BOARD_READER_SKIP_EMPTY_EN
  logic [SQ_W-1:0] last_q, last_d, last_sq;
  logic            unused_last_none, unused_next_none;

  board_next_square #(.DESCEND(1'b0)) u_first (
    .board_i(board), .base_i('0), .incl_i(1'b1),
    .idx_o(first_sq), .none_o(first_none)
  );
  board_next_square #(.DESCEND(1'b1)) u_last (
    .board_i(board), .base_i(SQ_W'(SQUARES - 1)), .incl_i(1'b1),
    .idx_o(last_sq), .none_o(unused_last_none)
  );
  // Searched over the snapshot, so later board changes cannot steer the frame.
  board_next_square #(.DESCEND(1'b0)) u_next (
    .board_i(snap_q), .base_i(idx_q), .incl_i(1'b0),
    .idx_o(next_sq), .none_o(unused_next_none)
  );

  assign is_last = (idx_q == last_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_q <= '0;
    else        last_q <= last_d;
  end

  always_comb begin
    last_d = last_q;
    if ((state_q == ST_IDLE) && start) last_d = last_sq;
  end
`else
  assign first_sq   = '0;
  assign first_none = 1'b0;
  assign next_sq    = idx_q + SQ_W'(1);
  assign is_last    = (idx_q == SQ_W'(SQUARES - 1));
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      idx_q   <= '0;
      turn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      idx_q   <= idx_d;
      turn_q  <= turn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    idx_d   = idx_q;
    turn_d  = turn_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          snap_d  = board;
          turn_d  = moveData[TURN_BIT];
          idx_d   = first_sq;
          state_d = first_none ? ST_DONE : ST_SEND;
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          if (is_last) state_d = ST_DONE;
          else         idx_d   = next_sq;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs depend only on registers, so out_ready never reaches out_valid combinationally.
  assign out_valid  = (state_q == ST_SEND);
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);
  assign out_square = out_valid ? idx_q : '0;
  assign out_piece  = out_valid ? snap_q[idx_q*PIECE_W +: PIECE_W] : '0;
  assign out_last   = out_valid & is_last;
  assign out_turn   = turn_q;

endmodule

// File: tb/tb_board_reader.sv
// Randomized self-checking bench for board_reader against a queue-based frame model.
// Honours BOARD_READER_SKIP_EMPTY_EN in the model when the design is built with it.
module tb_board_reader;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] board;
  logic [13:0]  moveData;
  logic         start;
  logic         out_ready;
  logic         busy, out_valid, out_turn, out_last, frame_done;
  logic [5:0]   out_square;
  logic [3:0]   out_piece;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  board_reader dut (
    .clk       (clk),
    .reset     (reset),
    .board     (board),
    .moveData  (moveData),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_square(out_square),
    .out_piece (out_piece),
    .out_turn  (out_turn),
    .out_last  (out_last),
    .frame_done(frame_done)
  );

  typedef struct {
    logic [5:0] sq;
    logic [3:0] pc;
    logic       last;
  } beat_t;

  beat_t expq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected frame: squares in index order, empties dropped when skipping, last flagged.
  function automatic void build_expected(input logic [255:0] b);
    beat_t bt;
    expq.delete();
    for (int i = 0; i < 64; i++) begin
      bt.sq   = 6'(i);
      bt.pc   = b[4*i +: 4];
      bt.last = 1'b0;
`ifdef BOARD_READER_SKIP_EMPTY_EN
      if (bt.pc != 4'h0) expq.push_back(bt);
`else
      expq.push_back(bt);
`endif
    end
    if (expq.size() > 0) expq[expq.size()-1].last = 1'b1;
  endfunction

  // ready_mode: 0 always ready, 1 random, 2 five-cycle stall at beat 10.
  task automatic run_frame(input int ready_mode, input int poke_at, input int abort_at,
                           output int exp_n, output int done_lat);
    logic exp_turn;
    int   beats = 0;
    int   stall = 0;
    bit   poked = 1'b0;
    build_expected(board);
    exp_n    = expq.size();
    exp_turn = moveData[13];
    done_lat = -1;
    start = 1'b1;
    tick();
    for (int cyc = 1; cyc < 1000; cyc++) begin
      start = 1'b0;
      if (abort_at >= 0 && beats == abort_at && expq.size() > 0) begin
        reset = 1'b0;
        #1;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_square", out_square, 0);
        check("abort_piece", out_piece, 0);
        check("abort_turn", out_turn, 0);
        check("abort_last", out_last, 0);
        check("abort_done", frame_done, 0);
        repeat (2) begin
          tick();
          check("abort_no_done", frame_done, 0);
        end
        reset = 1'b1;
        expq.delete();
        return;
      end
      if (expq.size() > 0) begin
        case (ready_mode)
          0: out_ready = 1'b1;
          1: out_ready = 1'($urandom_range(0, 1));
          default: begin
            out_ready = !(beats == 10 && stall < 5);
            if (!out_ready) stall++;
          end
        endcase
        check("valid", out_valid, 1);
        check("busy", busy, 1);
        check("done_early", frame_done, 0);
        check("square", out_square, expq[0].sq);
        check("piece", out_piece, expq[0].pc);
        check("last", out_last, expq[0].last);
        check("turn", out_turn, exp_turn);
        if (out_ready) begin
          void'(expq.pop_front());
          beats++;
        end
        if (poke_at >= 0 && !poked && beats == poke_at) begin
          poked          = 1'b1;
          board[80 +: 4] = 4'hF;
          moveData[13]   = ~moveData[13];
          start          = 1'b1;
        end
      end else begin
        check("frame_done", frame_done, 1);
        check("busy_done", busy, 1);
        check("valid_done", out_valid, 0);
        done_lat = cyc;
        break;
      end
      tick();
    end
    if (done_lat < 0) check("frame_timeout", frame_done, 1);
    out_ready = 1'b1;
  endtask

  task automatic post_idle();
    tick();
    check("idle_busy", busy, 0);
    check("idle_valid", out_valid, 0);
    check("idle_done", frame_done, 0);
  endtask

  task automatic ramp_board();
    for (int i = 0; i < 64; i++) board[4*i +: 4] = 4'(i);
  endtask

  initial begin
    int n, lat;
    reset     = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    board     = '0;
    moveData  = '0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_square", out_square, 0);
    check("rst_piece", out_piece, 0);
    check("rst_turn", out_turn, 0);
    check("rst_last", out_last, 0);
    check("rst_done", frame_done, 0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (4) begin
      tick();
      check("idle_busy0", busy, 0);
      check("idle_valid0", out_valid, 0);
    end

    // Full frame with ready held high, then back-to-back backpressure frame.
    ramp_board();
    moveData = 14'h2000;
    run_frame(0, -1, -1, n, lat);
    check("done_latency", lat, n + 1);
    post_idle();
    run_frame(2, -1, -1, n, lat);
    post_idle();

    // Random boards, turns and ready patterns.
    repeat (3) begin
      for (int k = 0; k < 8; k++) board[32*k +: 32] = $urandom;
      moveData = 14'($urandom);
      run_frame(1, -1, -1, n, lat);
      post_idle();
    end

    // Mid-frame board change and start are ignored; the next frame sees them.
    ramp_board();
    moveData = 14'h2000;
    run_frame(0, 5, -1, n, lat);
    post_idle();
    repeat (3) begin
      tick();
      check("no_second_frame", out_valid, 0);
    end
    run_frame(0, -1, -1, n, lat);
    post_idle();

    // Reset mid-frame, then a fresh frame from the first square.
    ramp_board();
    moveData = 14'h2000;
    run_frame(0, -1, 30, n, lat);
    tick();
    check("post_abort_valid", out_valid, 0);
    run_frame(0, -1, -1, n, lat);
    check("restart_latency", lat, n + 1);
    post_idle();

    // Sparse and all-empty boards.
    board = '0;
    board[3*4 +: 4]  = 4'h2;
    board[60*4 +: 4] = 4'hA;
    run_frame(0, -1, -1, n, lat);
    check("sparse_latency", lat, n + 1);
    post_idle();
    board = '0;
    run_frame(0, -1, -1, n, lat);
    check("empty_latency", lat, n + 1);
    post_idle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/board_reader.md
Name: board_reader

Overview:
- Reads the 256-bit packed chess board (64 squares x 4-bit piece codes) produced by the board builder.
- Streams it out one square per beat over a valid/ready handshake, for consumers such as the VGA renderer and the UART debug dump.
- Takes an atomic snapshot when a frame is started, so board updates mid-frame never tear a frame.
- Sits beside the board top, on the read side of the board bus.

Parameters:
- SQUARES, 64, number of squares per frame; square index width is clog2(SQUARES).
- PIECE_W, 4, bits per square; board width is SQUARES*PIECE_W.

Ports:
- clk  in  1  system clock (48.8 kHz domain).
- reset  in  1  asynchronous, active-low reset.
- board  in  256  packed board; square i = board[4i+3:4i].
- moveData  in  14  move word; only bit 13 (side to move) is used.
- start  in  1  request a frame; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted through the DONE cycle.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts the beat when out_valid & out_ready.
- out_square  out  6  square index of the current beat.
- out_piece  out  4  piece code of the current beat.
- out_turn  out  1  moveData[13] captured at start; constant for the whole frame.
- out_last  out  1  final beat of the frame.
- frame_done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE, snapshot=0, index=0.
  - All outputs are 0: busy, out_valid, out_square, out_piece, out_turn, out_last, frame_done.
- States:
  - IDLE -> SEND on start: same edge captures snapshot<=board, out_turn<=moveData[13], index<=first square.
  - SEND: out_valid=1; out_square=index; out_piece=snapshot[index]. On handshake, advance index; on a handshake with out_last=1 -> DONE.
  - DONE: frame_done=1 and busy=1 for exactly one cycle, out_valid=0 -> IDLE.
- Latency: start sampled at edge N; out_valid rises in cycle N+1 carrying square 0.
  - With out_ready held high: beats occupy cycles N+1..N+64, frame_done is in N+65, busy is low in N+66.
  - The earliest next accepted start is in cycle N+66.
- Handshake rules:
  - While out_valid & !out_ready, out_square, out_piece, out_last and out_turn hold stable.
  - out_valid never drops without a handshake, except on reset.
  - No combinational path from out_ready to out_valid.
- start is ignored in SEND and DONE; no queuing.
- board and moveData changes after the start edge have no effect on the current frame.
- out_last is high only together with out_valid, on the last square (index 63 by default).
- Index arithmetic is 6-bit unsigned with no wrap-around: the frame ends via out_last before the index overflows.
- Reset mid-frame aborts immediately: no frame_done, outputs as at reset.

Optional Feature:
- Macro: BOARD_READER_SKIP_EMPTY_EN.
- Defined: squares whose snapshot code is 0 (empty) are skipped.
  - The first beat is the lowest non-empty square.
  - Next-index selection is a priority search from index+1.
  - out_last marks the highest non-empty square.
  - If the snapshot is all-empty: no beats; SEND is bypassed, IDLE -> DONE, frame_done in cycle N+1.
  - Latency per beat is still one cycle; no bubbles between beats.
- Undefined: all 64 squares are sent in index order, empties included.

Decomposition:
- Shared package board_pkg:
  - SQUARES, PIECE_W, SQ_W=6, BOARD_W=256.
  - TURN_BIT=13.
  - Piece-code constants (EMPTY=4'h0, etc.).
  - Reader state encoding.
- Natural sub-module: board_next_square.
  - Combinational priority search returning the next non-empty index above a given index, plus a none-left flag.
  - Instantiated only under BOARD_READER_SKIP_EMPTY_EN.
  - Also used to compute the first and last non-empty squares at start.

Test Plan:
- Reset: assert reset=0 mid-simulation -> every output 0 in the same cycle, without waiting for a clock edge; release, start=0 -> stays IDLE, busy=0.
- Full frame: board has square i = i[3:0], moveData[13]=1, out_ready=1, pulse start at N.
  - Beats N+1..N+64 carry square 0..63 with piece i mod 16; out_turn=1 on all beats.
  - out_last only at square 63; frame_done at N+65; busy=0 at N+66.
- Backpressure: out_ready low for 5 cycles at square 10 -> square 10 / piece held stable and out_valid stays 1; resumes with square 11 after ready returns.
  - Random ready pattern -> exactly 64 handshakes, in order.
- Snapshot and ignore: change board square 20 to 4'hF and pulse start during a frame -> the frame still emits the original square 20 code; no second frame starts; next start after IDLE emits 4'hF.
- Reset mid-frame: reset=0 at beat 30 -> out_valid=0 immediately, no frame_done.
  - After release, a new start sends from square 0.
- With BOARD_READER_SKIP_EMPTY_EN: pieces only at squares 3 (code 4'h2) and 60 (code 4'hA) -> exactly two beats, (3,2) then (60,A) with out_last=1, frame_done the next cycle.
  - All-empty board -> zero beats, frame_done at N+1.
